// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_pkg
//  Description : Shared sizing constants, the signed data word type and the
//                signed-maximum helper for the maxpool1d_stream stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

  localparam int T      = 16;                 // data word width
  localparam int N_IN   = 9;                  // conv outputs per vector
  localparam int POOL   = 2;                  // window length and stride
  localparam int N_OUT  = N_IN / POOL;        // pooled outputs per vector
  localparam int ADDR_I = $clog2(N_IN + 1);   // input index counter width
  localparam int ADDR_W = $clog2(POOL + 1);   // window counter width
  localparam int ADDR_O = $clog2(N_OUT + 1);  // output index counter width

  typedef logic signed [T-1:0] data_t;

  // Signed maximum; on a tie both operands are equal so either is correct.
  function automatic data_t smax(input data_t a, input data_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pool_out_stage
//  Description : Single-entry output register for the pooled stream. Loads a
//                new word on load (which may coincide with a drain), clears
//                valid/last on a drain with no load, holds otherwise.
//  Ports       : clk, reset      - clock / async active-high reset
//                load            - a window completed this cycle
//                load_data/last  - word and end-of-vector flag to register
//                ready           - downstream accepts the held word
//                valid/data/last - registered output word
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_out_stage
  import pool_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic signed [T-1:0] load_data,
  input  logic                load_last,
  input  logic                ready,
  output logic                valid,
  output logic signed [T-1:0] data,
  output logic                last
);

  logic                r_valid;
  logic signed [T-1:0] r_data;
  logic                r_last;

  // The parent only raises load when the register is empty or draining,
  // so a load never overwrites a word that has not been taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
      r_last  <= load_last;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign last  = r_last;

endmodule
`default_nettype wire

// File: rtl/maxpool1d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool1d_stream
//  Description : Streaming 1-D max-pool, non-overlapping windows of POOL words
//                (stride POOL) over vectors of N_IN signed words. Emits N_OUT
//                maxima per vector; trailing words that do not fill a window
//                are accepted and discarded. Last pooled word is flagged.
//  Ports       : clk, reset                  - clock / async active-high reset
//                s_data_in_x/s_valid_x/s_ready_x - input stream
//                m_data_out_y/m_valid_y/m_ready_y/m_last_y - pooled stream
//  Revision    : 1.0 - initial release
// ============================================================================
module maxpool1d_stream
  import pool_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] s_data_in_x,
  input  logic                s_valid_x,
  output logic                s_ready_x,
  output logic signed [T-1:0] m_data_out_y,
  output logic                m_valid_y,
  input  logic                m_ready_y,
  output logic                m_last_y
);

  localparam logic [ADDR_I-1:0] c_idx_last   = ADDR_I'(N_IN - 1);
  localparam logic [ADDR_I-1:0] c_tail_start = ADDR_I'(N_OUT * POOL);
  localparam logic [ADDR_W-1:0] c_win_last   = ADDR_W'(POOL - 1);
  localparam logic [ADDR_O-1:0] c_out_last   = ADDR_O'(N_OUT - 1);

  logic [ADDR_I-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_win;
  logic [ADDR_O-1:0]   r_out_idx;
  logic signed [T-1:0] r_acc;

  logic                w_tail;
  logic                w_candidate;
  logic                w_accept;
  logic                w_complete;
  logic signed [T-1:0] w_next_acc;

  assign w_tail      = (r_idx >= c_tail_start);
  assign w_candidate = (r_win == c_win_last) && !w_tail;

  // Only a window-completing beat needs a free output slot; all other beats
  // just update counters/acc and are never stalled. Ready is combinational
  // on m_ready_y so a drain and a load can share one cycle.
  assign s_ready_x  = !w_candidate || !m_valid_y || m_ready_y;
  assign w_accept   = s_valid_x && s_ready_x;
  assign w_complete = w_accept && w_candidate;

  // First word of a window seeds the running max. With POOL==1 every beat
  // is a first word, so this is also the pooled result on a completing beat.
  assign w_next_acc = (r_win == '0) ? s_data_in_x : smax(r_acc, s_data_in_x);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_win     <= '0;
      r_out_idx <= '0;
      r_acc     <= '0;
    end else if (w_accept) begin
      r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      if (w_tail) begin
        r_win <= '0;
      end else begin
        r_win <= (r_win == c_win_last) ? '0 : r_win + 1'b1;
        r_acc <= w_next_acc;
      end
      if (w_candidate) begin
        r_out_idx <= (r_out_idx == c_out_last) ? '0 : r_out_idx + 1'b1;
      end
    end
  end

  pool_out_stage u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (w_complete),
    .load_data (w_next_acc),
    .load_last (r_out_idx == c_out_last),
    .ready     (m_ready_y),
    .valid     (m_valid_y),
    .data      (m_data_out_y),
    .last      (m_last_y)
  );

endmodule
`default_nettype wire

// File: tb/tb_maxpool1d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool1d_stream
//  Description : Self-checking bench for maxpool1d_stream. Accepted beats feed
//                a frame-buffer reference model that pushes expected pooled
//                words into a scoreboard queue; a monitor pops and compares
//                on every output transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool1d_stream;
  import pool_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [T-1:0] s_data_in_x;
  logic                s_valid_x;
  logic                s_ready_x;
  logic signed [T-1:0] m_data_out_y;
  logic                m_valid_y;
  logic                m_ready_y;
  logic                m_last_y;

  always #5 clk = ~clk;

  maxpool1d_stream dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_in_x  (s_data_in_x),
    .s_valid_x    (s_valid_x),
    .s_ready_x    (s_ready_x),
    .m_data_out_y (m_data_out_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y),
    .m_last_y     (m_last_y)
  );

  int checks = 0;
  int errors = 0;

  logic [T:0]          exp_q[$];   // {last, data}
  logic [T:0]          obs_q[$];
  logic signed [T-1:0] frame[$];
  logic                cflag = 1'b0;
  int                  rmode = 0;  // 0 static, 1 toggle, 2 random

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // m_ready_y pattern generator
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: m_ready_y = ~m_ready_y;
      2: m_ready_y = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Reference model: collect the vector, emit the max of each full window.
  int                  w_pos;
  logic signed [T-1:0] w_mx;
  logic                w_c;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      frame.delete();
      cflag <= 1'b0;
    end else begin
      w_c = 1'b0;
      if (s_valid_x && s_ready_x) begin
        frame.push_back(s_data_in_x);
        w_pos = frame.size() - 1;
        if (((w_pos + 1) % POOL == 0) && (w_pos < N_OUT * POOL)) begin
          w_mx = frame[w_pos-POOL+1];
          for (int k = w_pos - POOL + 2; k <= w_pos; k++)
            if (frame[k] > w_mx) w_mx = frame[k];
          exp_q.push_back({((w_pos / POOL) == N_OUT - 1), w_mx});
          w_c = 1'b1;
        end
        if (frame.size() == N_IN) frame.delete();
      end
      cflag <= w_c;
    end
  end

  // Monitor: latency, hold rule and scoreboard comparison.
  logic       pv, pr, pl;
  int         pd;
  logic [T:0] e;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (cflag) chk("latency_valid", m_valid_y, 1);
      if (pv && !pr) begin
        chk("hold_valid", m_valid_y, 1);
        chk("hold_data", m_data_out_y, pd);
        chk("hold_last", m_last_y, pl);
      end
      if (m_valid_y && m_ready_y) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0d required=none", m_data_out_y);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_data_out_y, int'($signed(e[T-1:0])));
          chk("out_last", m_last_y, e[T]);
        end
        obs_q.push_back({m_last_y, m_data_out_y});
      end
      pv = m_valid_y;
      pr = m_ready_y;
      pd = m_data_out_y;
      pl = m_last_y;
    end
  end

  task automatic send(input int v, output logic rdy_first);
    int n = 0;
    s_data_in_x = v[T-1:0];
    s_valid_x   = 1'b1;
    @(negedge clk);
    rdy_first = s_ready_x;
    while (!s_ready_x && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_x) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid_x = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid_y) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic chk_obs(input string name, input int i, input int d, input int l);
    if (i >= obs_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s actual=missing required=%0d", name, d);
    end else begin
      chk(name, int'($signed(obs_q[i][T-1:0])), d);
      chk({name, "_last"}, obs_q[i][T], l);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  int   basic_v[9]   = '{5, -3, 7, 7, 0, 2, -10, -20, 99};
  int   ext_v[9]     = '{-32768, -1, 32767, -32768, 1, 2, 3, 4, 5};
  int   pre_v[3]     = '{5, -3, 7};
  logic r;

  initial begin
    reset       = 1'b1;
    s_valid_x   = 1'b0;
    s_data_in_x = '0;
    m_ready_y   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", m_valid_y, 0);
    chk("rst_data", m_data_out_y, 0);
    chk("rst_last", m_last_y, 0);
    chk("rst_ready", s_ready_x, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame
    obs_q.delete();
    foreach (basic_v[i]) begin
      send(basic_v[i], r);
      chk("basic_ready", r, 1);
    end
    idle();
    drain();
    chk("basic_count", obs_q.size(), 4);
    chk_obs("basic_o0", 0, 5, 0);
    chk_obs("basic_o1", 1, 7, 0);
    chk_obs("basic_o2", 2, 2, 0);
    chk_obs("basic_o3", 3, -10, 1);

    // Back-pressure
    obs_q.delete();
    m_ready_y = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(basic_v[i], r);
      chk("bp_ready_early", r, 1);
    end
    s_data_in_x = 16'sd7;
    s_valid_x   = 1'b1;
    @(negedge clk);
    chk("bp_ready_low", s_ready_x, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_low2", s_ready_x, 0);
    @(posedge clk);
    #1;
    m_ready_y = 1'b1;
    send(7, r);
    chk("bp_release", r, 1);
    for (int i = 4; i < 9; i++) send(basic_v[i], r);
    idle();
    drain();
    chk("bp_count", obs_q.size(), 4);
    chk_obs("bp_o0", 0, 5, 0);
    chk_obs("bp_o1", 1, 7, 0);

    // Signed extremes
    obs_q.delete();
    foreach (ext_v[i]) send(ext_v[i], r);
    idle();
    drain();
    chk_obs("ext_o0", 0, -1, 0);
    chk_obs("ext_o1", 1, 32767, 0);
    chk_obs("ext_o2", 2, 2, 0);
    chk_obs("ext_o3", 3, 4, 1);

    // Back-to-back frames
    obs_q.delete();
    for (int i = 0; i < 2 * N_IN; i++) send(int'($signed(16'($urandom))), r);
    idle();
    drain();
    chk("b2b_count", obs_q.size(), 2 * N_OUT);
    for (int i = 0; i < obs_q.size(); i++)
      chk("b2b_last", obs_q[i][T], int'(i == 3 || i == 7));

    // Toggling m_ready_y under continuous input
    rmode = 1;
    for (int i = 0; i < 3 * N_IN; i++) send(int'($signed(16'($urandom))), r);
    idle();
    drain();
    rmode = 0;
    m_ready_y = 1'b1;

    // Random gaps and random back-pressure
    rmode = 2;
    for (int i = 0; i < 5 * N_IN; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send(int'($signed(16'($urandom))), r);
    end
    idle();
    drain();
    rmode = 0;
    @(posedge clk);
    #1;
    m_ready_y = 1'b1;

    // Reset mid-window
    foreach (pre_v[i]) send(pre_v[i], r);
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    obs_q.delete();
    for (int i = 1; i <= 9; i++) send(i, r);
    idle();
    drain();
    chk("rstmid_count", obs_q.size(), 4);
    chk_obs("rstmid_o0", 0, 2, 0);
    chk_obs("rstmid_o1", 1, 4, 0);
    chk_obs("rstmid_o2", 2, 6, 0);
    chk_obs("rstmid_o3", 3, 8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
